// File: rtl/c432_bist_sequencer.sv
// BIST sequencer for the registered c432 wrapper: LFSR pattern source, latency-aligned
// valid pipe and 16-bit MISR response compactor with a pass/fail compare.
module c432_bist_sequencer #(
    parameter int unsigned NUM_VECTORS = 1024,
    parameter int unsigned LAT         = 3,
    parameter logic [35:0] DEF_SEED    = 36'h000000001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        seed_load,
    input  logic [35:0] seed,
    input  logic [15:0] exp_sig,
    output logic [35:0] dut_in,
    input  logic [6:0]  dut_q,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] vec_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [15:0] LAST_ISSUE = 16'(NUM_VECTORS - 1);

    state_t          state, state_nxt;
    logic [35:0]     seed_reg;
    logic [35:0]     lfsr;
    logic [35:0]     seed_src;
    logic [15:0]     issue_cnt;
    logic [LAT-1:0]  vld_pipe;
    logic [LAT:0]    vld_shift;
    logic            idle_like;
    logic            compact;
    logic            pipe_empty;
    logic [15:0]     sig_nxt;

    assign idle_like  = (state == IDLE) || (state == DONE);
    assign compact    = vld_pipe[LAT-1];
    assign pipe_empty = (vld_pipe == '0);
    // a seed presented together with start must win over the stored one
    assign seed_src   = seed_load ? seed : seed_reg;
    assign vld_shift  = {vld_pipe, (state == RUN)};
    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);

    always_comb begin
        sig_nxt = signature;
        if (compact)
            sig_nxt = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000)
                      ^ {9'b0, dut_q};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start)                     state_nxt = RUN;
            RUN:        if (issue_cnt == LAST_ISSUE)   state_nxt = DRAIN;
            DRAIN:      if (pipe_empty)                state_nxt = DONE;
            default:                                   state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_reg  <= DEF_SEED;
            lfsr      <= DEF_SEED;
            dut_in    <= '0;
            issue_cnt <= '0;
            vld_pipe  <= '0;
            signature <= '0;
            vec_count <= '0;
            pass      <= 1'b0;
        end else begin
            if (idle_like && seed_load)
                seed_reg <= seed;
            if (abort) begin
                vld_pipe <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            lfsr      <= (seed_src == '0) ? 36'h1 : seed_src;
                            issue_cnt <= '0;
                            vld_pipe  <= '0;
                            signature <= '0;
                            vec_count <= '0;
                            pass      <= 1'b0;
                        end
                    end
                    RUN, DRAIN: begin
                        vld_pipe <= vld_shift[LAT-1:0];
                        if (state == RUN) begin
                            dut_in    <= lfsr;
                            lfsr      <= {lfsr[34:0], lfsr[35] ^ lfsr[24]};
                            issue_cnt <= issue_cnt + 16'd1;
                        end
                        if (compact) begin
                            signature <= sig_nxt;
                            if (vec_count != 16'hFFFF)
                                vec_count <= vec_count + 16'd1;
                        end
                        if (state == DRAIN && pipe_empty)
                            pass <= (sig_nxt == exp_sig);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
